// File: rtl/bp_fe_icache_fetch_driver_if.sv
// Fetch-driver bus bundle: request source, I$ vaddr/ptag/data ports,
// in-order output port and performance counters.
interface bp_fe_icache_fetch_driver_if #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28,
    parameter int instr_width_p = 32,
    parameter int cnt_width_p   = 16
);
    // request source
    logic [vaddr_width_p+ptag_width_p:0] req_i;
    logic                                req_v_i;
    logic                                req_yumi_o;
    // I$ two-phase interface
    logic [vaddr_width_p-1:0]            vaddr_o;
    logic                                vaddr_v_o;
    logic                                vaddr_ready_i;
    logic [ptag_width_p-1:0]             ptag_o;
    logic                                ptag_v_o;
    logic                                uncached_o;
    logic [instr_width_p-1:0]            data_i;
    logic                                data_v_i;
    logic                                miss_i;
    // in-order output
    logic [instr_width_p-1:0]            data_o;
    logic                                data_v_o;
    logic                                data_yumi_i;
    // performance counters
    logic [cnt_width_p-1:0]              miss_cnt_o;
    logic [cnt_width_p-1:0]              fetch_cnt_o;

    // fetch driver side
    modport master (
        input  req_i, req_v_i, vaddr_ready_i, data_i, data_v_i, miss_i, data_yumi_i,
        output req_yumi_o, vaddr_o, vaddr_v_o, ptag_o, ptag_v_o, uncached_o,
        output data_o, data_v_o, miss_cnt_o, fetch_cnt_o
    );

    // environment side (request source, I$, consumer)
    modport slave (
        output req_i, req_v_i, vaddr_ready_i, data_i, data_v_i, miss_i, data_yumi_i,
        input  req_yumi_o, vaddr_o, vaddr_v_o, ptag_o, ptag_v_o, uncached_o,
        input  data_o, data_v_o, miss_cnt_o, fetch_cnt_o
    );
endinterface

// File: rtl/bp_fe_icache_fetch_driver.sv
// I$ fetch driver: issues fetch packets over the vaddr/ptag two-phase
// interface, keeps up to two fetches in flight (TL, TV), replays killed
// fetches in order after a miss and returns instructions in order through
// a credit-protected output FIFO.

// Protocol checker for the I$ response and ptag outputs.
module bp_fe_icache_fetch_driver_checker (
    input logic clk_i,
    input logic reset_i,
    input logic data_v_i,
    input logic miss_i,
    input logic tl_v,
    input logic tv_v,
    input logic ptag_v_o
);
    hit_and_miss_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(data_v_i && miss_i));
    resp_without_tv_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !((data_v_i || miss_i) && !tv_v));
    ptag_without_tl_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(ptag_v_o && !tl_v));
endmodule

module bp_fe_icache_fetch_driver #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28,
    parameter int instr_width_p = 32,
    parameter int out_els_p     = 4,
    parameter int cnt_width_p   = 16
) (
    input logic clk_i,
    input logic reset_i,
    bp_fe_icache_fetch_driver_if.master bus
);
    localparam int pkt_w = 1 + vaddr_width_p + ptag_width_p;
    localparam int ptr_w = (out_els_p > 1) ? $clog2(out_els_p) : 1;
    localparam int occ_w = $clog2(out_els_p + 1);
    localparam int sum_w = occ_w + 1;
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(out_els_p - 1);

    typedef enum logic [1:0] {
        st_run       = 2'd0,
        st_miss_wait = 2'd1,
        st_replay    = 2'd2
    } state_e;

    state_e state_r, state_s;

    logic             tl_v_r, tv_v_r;
    logic [pkt_w-1:0] tl_pkt_r, tv_pkt_r;
    logic [pkt_w-1:0] rq_r [2];
    logic [1:0]       rq_cnt_r;
    logic [pkt_w-1:0] rq0_s, rq1_s;
    logic [1:0]       rq_cnt_s;

    logic [instr_width_p-1:0] buf_r [out_els_p];
    logic [ptr_w-1:0]         wr_ptr_r, rd_ptr_r;
    logic [occ_w-1:0]         occ_r;
    logic [cnt_width_p-1:0]   miss_cnt_r, fetch_cnt_r;

    logic             rq_nonempty_s, src_v_s, kill_s, credit_ok_s;
    logic             vaddr_v_s, hs_s, pop_s, wr_s, rd_s, ptag_v_s;
    logic [pkt_w-1:0] src_pkt_s;
    logic [sum_w-1:0] used_s;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        if (p == last_ptr) begin
            return {ptr_w{1'b0}};
        end else begin
            return p + ptr_w'(1'b1);
        end
    endfunction

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + cnt_width_p'(1'b1);
        end
    endfunction

    // Issue source selection, credit check and handshake decode.
    always_comb begin
        rq_nonempty_s = (rq_cnt_r != 2'd0);
        src_pkt_s     = rq_nonempty_s ? rq_r[0] : bus.req_i;
        src_v_s       = rq_nonempty_s | bus.req_v_i;
        kill_s        = bus.miss_i & tv_v_r;
        used_s        = {1'b0, occ_r} + sum_w'(tl_v_r) + sum_w'(tv_v_r);
        credit_ok_s   = (used_s < sum_w'(out_els_p));
        vaddr_v_s     = ((state_r == st_run) || (state_r == st_replay))
                        & src_v_s & ~bus.miss_i & credit_ok_s;
        hs_s          = vaddr_v_s & bus.vaddr_ready_i;
        pop_s         = hs_s & rq_nonempty_s;
        wr_s          = bus.data_v_i & tv_v_r;
        rd_s          = bus.data_yumi_i & (occ_r != {occ_w{1'b0}});
        ptag_v_s      = tl_v_r & ~kill_s;
    end

    // Output drive; address/tag fields read as zero when not valid.
    always_comb begin
        bus.req_yumi_o  = hs_s & ~rq_nonempty_s;
        bus.vaddr_v_o   = vaddr_v_s;
        bus.vaddr_o     = vaddr_v_s ? src_pkt_s[ptag_width_p +: vaddr_width_p]
                                    : {vaddr_width_p{1'b0}};
        bus.ptag_v_o    = ptag_v_s;
        bus.ptag_o      = ptag_v_s ? tl_pkt_r[ptag_width_p-1:0] : {ptag_width_p{1'b0}};
        bus.uncached_o  = ptag_v_s & tl_pkt_r[pkt_w-1];
        bus.data_v_o    = (occ_r != {occ_w{1'b0}});
        bus.data_o      = bus.data_v_o ? buf_r[rd_ptr_r] : {instr_width_p{1'b0}};
        bus.miss_cnt_o  = miss_cnt_r;
        bus.fetch_cnt_o = fetch_cnt_r;
    end

    // FSM next state: RUN -> MISS_WAIT on miss, wait for fill, replay, back to RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            st_run: begin
                if (kill_s) begin
                    state_s = st_miss_wait;
                end else begin
                    state_s = st_run;
                end
            end
            st_miss_wait: begin
                if (bus.vaddr_ready_i) begin
                    state_s = st_replay;
                end else begin
                    state_s = st_miss_wait;
                end
            end
            st_replay: begin
                if (kill_s) begin
                    state_s = st_miss_wait;
                end else if ((pop_s && (rq_cnt_r == 2'd1)) || !rq_nonempty_s) begin
                    state_s = st_run;
                end else begin
                    state_s = st_replay;
                end
            end
            default: state_s = st_run;
        endcase
    end

    // Replay queue next value: killed fetches go in front (older first), issue pops head.
    always_comb begin
        rq0_s    = rq_r[0];
        rq1_s    = rq_r[1];
        rq_cnt_s = rq_cnt_r;
        if (kill_s) begin
            if (tl_v_r) begin
                rq0_s    = tv_pkt_r;
                rq1_s    = tl_pkt_r;
                rq_cnt_s = 2'd2;
            end else begin
                rq0_s    = tv_pkt_r;
                rq1_s    = rq_r[0];
                rq_cnt_s = rq_cnt_r + 2'd1;
            end
        end else if (pop_s) begin
            rq0_s    = rq_r[1];
            rq1_s    = rq_r[1];
            rq_cnt_s = rq_cnt_r - 2'd1;
        end else begin
            rq_cnt_s = rq_cnt_r;
        end
    end

    // FSM state, replay queue and TL/TV pipeline registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= st_run;
            rq_r[0]  <= {pkt_w{1'b0}};
            rq_r[1]  <= {pkt_w{1'b0}};
            rq_cnt_r <= 2'd0;
            tl_v_r   <= 1'b0;
            tv_v_r   <= 1'b0;
            tl_pkt_r <= {pkt_w{1'b0}};
            tv_pkt_r <= {pkt_w{1'b0}};
        end else begin
            state_r  <= state_s;
            rq_r[0]  <= rq0_s;
            rq_r[1]  <= rq1_s;
            rq_cnt_r <= rq_cnt_s;
            tl_v_r   <= hs_s;
            if (hs_s) begin
                tl_pkt_r <= src_pkt_s;
            end
            tv_v_r   <= tl_v_r & ~kill_s;
            tv_pkt_r <= tl_pkt_r;
        end
    end

    // Output FIFO storage; contents are only visible while occupied.
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            buf_r[wr_ptr_r] <= bus.data_i;
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {ptr_w{1'b0}};
            rd_ptr_r <= {ptr_w{1'b0}};
            occ_r    <= {occ_w{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (rd_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({wr_s, rd_s})
                2'b10:   occ_r <= occ_r + occ_w'(1'b1);
                2'b01:   occ_r <= occ_r - occ_w'(1'b1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Saturating miss and returned-instruction counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            miss_cnt_r  <= {cnt_width_p{1'b0}};
            fetch_cnt_r <= {cnt_width_p{1'b0}};
        end else begin
            if (kill_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
            if (rd_s) begin
                fetch_cnt_r <= sat_inc(fetch_cnt_r);
            end
        end
    end

    bp_fe_icache_fetch_driver_checker u_checker (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .data_v_i (bus.data_v_i),
        .miss_i   (bus.miss_i),
        .tl_v     (tl_v_r),
        .tv_v     (tv_v_r),
        .ptag_v_o (bus.ptag_v_o)
    );
endmodule

// File: tb/tb_bp_fe_icache_fetch_driver.sv
// Bench for the I$ fetch driver: per-cycle vector table for hits and an
// uncached fetch, plus directed sequences for miss/replay, backpressure
// and mid-flight reset. A small I$ responder answers each real handshake
// two cycles later, missing on a chosen address a chosen number of times.
module tb_bp_fe_icache_fetch_driver;
    localparam int vw = 39;
    localparam int pw = 28;
    localparam int iw = 32;
    localparam int cw = 16;

    localparam logic [vw-1:0] a0 = 39'h00_8000_0000;
    localparam logic [vw-1:0] a1 = 39'h00_8000_0004;
    localparam logic [vw-1:0] a2 = 39'h00_8000_0008;
    localparam logic [vw-1:0] a3 = 39'h00_8000_000C;
    localparam logic [vw-1:0] au = 39'h00_8000_0040;
    localparam logic [pw-1:0] p0 = 28'h000_0100;
    localparam logic [pw-1:0] p1 = 28'h000_0101;
    localparam logic [pw-1:0] p2 = 28'h000_0102;
    localparam logic [pw-1:0] p3 = 28'h000_0103;
    localparam logic [pw-1:0] pu = 28'h008_0000;
    localparam logic [vw-1:0] z0 = 39'h00_0000_0000;
    localparam logic [pw-1:0] pz = 28'h000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_fe_icache_fetch_driver_if #(.vaddr_width_p(vw), .ptag_width_p(pw),
                                   .instr_width_p(iw), .cnt_width_p(cw)) bus ();

    bp_fe_icache_fetch_driver #(.vaddr_width_p(vw), .ptag_width_p(pw), .instr_width_p(iw),
                                .out_els_p(4), .cnt_width_p(cw)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // I$ responder state and values sampled at the falling edge
    logic          m_tl_v, m_tv_v;
    logic [vw-1:0] m_tl_a, m_tv_a;
    logic [vw-1:0] miss_addr;
    int            miss_left;
    logic          s_hs, s_kill, s_reset, s_req_yumi, s_dv;
    logic [vw-1:0] s_addr;
    logic [iw-1:0] s_data;

    typedef struct {
        logic          req_v;
        logic          unc;
        logic [vw-1:0] va;
        logic [pw-1:0] pt;
        logic          yumi;
        logic          e_ry;
        logic          e_vv;
        logic          e_pv;
        logic [pw-1:0] e_pt;
        logic          e_unc;
        logic          e_dv;
        logic [iw-1:0] e_d;
        logic [cw-1:0] e_fc;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic rv, input logic u, input logic [vw-1:0] va,
                                input logic [pw-1:0] pt, input logic y, input logic ery,
                                input logic evv, input logic epv, input logic [pw-1:0] ept,
                                input logic eu, input logic edv, input logic [iw-1:0] ed,
                                input logic [cw-1:0] efc);
        vec_t v;
        v.req_v = rv; v.unc = u; v.va = va; v.pt = pt; v.yumi = y;
        v.e_ry = ery; v.e_vv = evv; v.e_pv = epv; v.e_pt = ept; v.e_unc = eu;
        v.e_dv = edv; v.e_d = ed; v.e_fc = efc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic u, input logic [vw-1:0] a,
                           input logic [pw-1:0] p);
        bus.req_v_i = v;
        bus.req_i   = {u, a, p};
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Sample this cycle, cross the rising edge, then drive the I$ response for the new TV.
    task automatic adv();
        s_hs       = bus.vaddr_v_o & bus.vaddr_ready_i;
        s_addr     = bus.vaddr_o;
        s_kill     = bus.miss_i & m_tv_v;
        s_reset    = reset;
        s_req_yumi = bus.req_yumi_o;
        s_dv       = bus.data_v_o & bus.data_yumi_i;
        s_data     = bus.data_o;
        @(posedge clk);
        #1;
        if (s_reset) begin
            m_tl_v = 1'b0;
            m_tv_v = 1'b0;
        end else begin
            m_tv_v = m_tl_v & ~s_kill;
            m_tv_a = m_tl_a;
            m_tl_v = s_hs;
            m_tl_a = s_addr;
        end
        bus.data_v_i = 1'b0;
        bus.miss_i   = 1'b0;
        bus.data_i   = 32'h0;
        if (m_tv_v) begin
            if (miss_left > 0 && m_tv_a == miss_addr) begin
                bus.miss_i = 1'b1;
                miss_left--;
            end else begin
                bus.data_v_i = 1'b1;
                bus.data_i   = m_tv_a[31:0];
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(1'b0, 1'b0, z0, pz);
        bus.vaddr_ready_i = 1'b1;
        bus.data_yumi_i   = 1'b0;
        bus.data_v_i      = 1'b0;
        bus.miss_i        = 1'b0;
        bus.data_i        = 32'h0;
        miss_left         = 0;
        miss_addr         = z0;
        adv();
        adv();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_yumi"}, 64'(bus.req_yumi_o), 64'h0);
        chk({tag, "_vaddr_v"},  64'(bus.vaddr_v_o),  64'h0);
        chk({tag, "_vaddr"},    64'(bus.vaddr_o),    64'h0);
        chk({tag, "_ptag_v"},   64'(bus.ptag_v_o),   64'h0);
        chk({tag, "_ptag"},     64'(bus.ptag_o),     64'h0);
        chk({tag, "_uncached"}, 64'(bus.uncached_o), 64'h0);
        chk({tag, "_data_v"},   64'(bus.data_v_o),   64'h0);
        chk({tag, "_data"},     64'(bus.data_o),     64'h0);
        chk({tag, "_miss_cnt"}, 64'(bus.miss_cnt_o), 64'h0);
        chk({tag, "_fetch_cnt"},64'(bus.fetch_cnt_o),64'h0);
    endtask

    initial begin
        int k;
        int n_hs;
        int n_out;
        logic [vw-1:0] hs_log [8];
        logic [iw-1:0] out_log [8];
        logic [vw-1:0] exp_hs [6];
        logic [vw-1:0] addr;

        m_tl_v = 1'b0; m_tv_v = 1'b0; m_tl_a = z0; m_tv_a = z0;

        // hits: four back-to-back fetches, ptag one cycle after issue, data three after
        vecs[0]  = mk(1'b1, 1'b0, a0, p0, 1'b0,  1'b1, 1'b1, 1'b0, pz, 1'b0, 1'b0, 32'h0, 16'd0);
        vecs[1]  = mk(1'b1, 1'b0, a1, p1, 1'b0,  1'b1, 1'b1, 1'b1, p0, 1'b0, 1'b0, 32'h0, 16'd0);
        vecs[2]  = mk(1'b1, 1'b0, a2, p2, 1'b0,  1'b1, 1'b1, 1'b1, p1, 1'b0, 1'b0, 32'h0, 16'd0);
        vecs[3]  = mk(1'b1, 1'b0, a3, p3, 1'b1,  1'b1, 1'b1, 1'b1, p2, 1'b0, 1'b1, 32'h8000_0000, 16'd0);
        vecs[4]  = mk(1'b0, 1'b0, z0, pz, 1'b1,  1'b0, 1'b0, 1'b1, p3, 1'b0, 1'b1, 32'h8000_0004, 16'd1);
        vecs[5]  = mk(1'b0, 1'b0, z0, pz, 1'b1,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b1, 32'h8000_0008, 16'd2);
        vecs[6]  = mk(1'b0, 1'b0, z0, pz, 1'b1,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b1, 32'h8000_000C, 16'd3);
        vecs[7]  = mk(1'b0, 1'b0, z0, pz, 1'b0,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b0, 32'h0, 16'd4);
        // uncached fetch: uncached/ptag visible only in the TL cycle
        vecs[8]  = mk(1'b1, 1'b1, au, pu, 1'b0,  1'b1, 1'b1, 1'b0, pz, 1'b0, 1'b0, 32'h0, 16'd4);
        vecs[9]  = mk(1'b0, 1'b0, z0, pz, 1'b0,  1'b0, 1'b0, 1'b1, pu, 1'b1, 1'b0, 32'h0, 16'd4);
        vecs[10] = mk(1'b0, 1'b0, z0, pz, 1'b0,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b0, 32'h0, 16'd4);
        vecs[11] = mk(1'b0, 1'b0, z0, pz, 1'b1,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b1, 32'h8000_0040, 16'd4);
        vecs[12] = mk(1'b0, 1'b0, z0, pz, 1'b0,  1'b0, 1'b0, 1'b0, pz, 1'b0, 1'b0, 32'h0, 16'd5);

        // ---- reset state ----
        do_reset();
        to_neg();
        chk_all_zero("rst");
        adv();

        // ---- table: hits and uncached ----
        for (int i = 0; i < 13; i++) begin
            set_req(vecs[i].req_v, vecs[i].unc, vecs[i].va, vecs[i].pt);
            bus.data_yumi_i = vecs[i].yumi;
            to_neg();
            chk($sformatf("v%0d_req_yumi", i), 64'(bus.req_yumi_o), 64'(vecs[i].e_ry));
            chk($sformatf("v%0d_vaddr_v", i),  64'(bus.vaddr_v_o),  64'(vecs[i].e_vv));
            chk($sformatf("v%0d_vaddr", i),    64'(bus.vaddr_o),    vecs[i].e_vv ? 64'(vecs[i].va) : 64'h0);
            chk($sformatf("v%0d_ptag_v", i),   64'(bus.ptag_v_o),   64'(vecs[i].e_pv));
            chk($sformatf("v%0d_ptag", i),     64'(bus.ptag_o),     64'(vecs[i].e_pt));
            chk($sformatf("v%0d_uncached", i), 64'(bus.uncached_o), 64'(vecs[i].e_unc));
            chk($sformatf("v%0d_data_v", i),   64'(bus.data_v_o),   64'(vecs[i].e_dv));
            chk($sformatf("v%0d_data", i),     64'(bus.data_o),     64'(vecs[i].e_d));
            chk($sformatf("v%0d_fetch_cnt", i),64'(bus.fetch_cnt_o),64'(vecs[i].e_fc));
            adv();
        end

        // ---- miss of A with B in TL, fill takes 10 not-ready cycles ----
        do_reset();
        miss_addr = a0;
        miss_left = 1;
        set_req(1'b1, 1'b0, a0, p0);
        to_neg();
        chk("m_issue_a", 64'(bus.req_yumi_o), 64'h1);
        adv();
        set_req(1'b1, 1'b0, a1, p1);
        to_neg();
        chk("m_issue_b", 64'(bus.req_yumi_o), 64'h1);
        chk("m_ptag_a", 64'(bus.ptag_o), 64'(p0));
        adv();
        set_req(1'b1, 1'b0, a2, p2);
        to_neg();
        chk("m_miss_vaddr_v", 64'(bus.vaddr_v_o), 64'h0);
        chk("m_miss_no_ptag_b", 64'(bus.ptag_v_o), 64'h0);
        chk("m_miss_req_yumi", 64'(bus.req_yumi_o), 64'h0);
        adv();
        bus.vaddr_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            chk("m_wait_vaddr_v", 64'(bus.vaddr_v_o), 64'h0);
            chk("m_wait_ptag_v", 64'(bus.ptag_v_o), 64'h0);
            chk("m_wait_req_yumi", 64'(bus.req_yumi_o), 64'h0);
            adv();
        end
        bus.vaddr_ready_i = 1'b1;
        to_neg();
        chk("m_fill_vaddr_v", 64'(bus.vaddr_v_o), 64'h0);
        adv();
        to_neg();
        chk("m_replay_a_v", 64'(bus.vaddr_v_o), 64'h1);
        chk("m_replay_a", 64'(bus.vaddr_o), 64'(a0));
        chk("m_replay_a_req_yumi", 64'(bus.req_yumi_o), 64'h0);
        adv();
        to_neg();
        chk("m_replay_b", 64'(bus.vaddr_o), 64'(a1));
        chk("m_replay_b_req_yumi", 64'(bus.req_yumi_o), 64'h0);
        chk("m_replay_ptag_a", 64'(bus.ptag_o), 64'(p0));
        adv();
        to_neg();
        chk("m_issue_c_req_yumi", 64'(bus.req_yumi_o), 64'h1);
        chk("m_issue_c", 64'(bus.vaddr_o), 64'(a2));
        chk("m_replay_ptag_b", 64'(bus.ptag_o), 64'(p1));
        adv();
        set_req(1'b0, 1'b0, z0, pz);
        bus.data_yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = a0 + 39'(4 * i);
            to_neg();
            chk($sformatf("m_out%0d_v", i), 64'(bus.data_v_o), 64'h1);
            chk($sformatf("m_out%0d", i), 64'(bus.data_o), 64'(addr[31:0]));
            adv();
        end
        to_neg();
        chk("m_out_empty", 64'(bus.data_v_o), 64'h0);
        chk("m_miss_cnt", 64'(bus.miss_cnt_o), 64'h1);
        chk("m_fetch_cnt", 64'(bus.fetch_cnt_o), 64'h3);
        adv();

        // ---- backpressure: consumer stalled, 4 credits ----
        do_reset();
        k = 0;
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            set_req(1'b1, 1'b0, a0 + 39'(4 * k), p0);
            to_neg();
            adv();
            if (s_hs) n_hs++;
            if (s_req_yumi) k++;
        end
        chk("bp_issued", 64'(n_hs), 64'h4);
        set_req(1'b1, 1'b0, a0 + 39'(4 * k), p0);
        to_neg();
        chk("bp_stalled", 64'(bus.vaddr_v_o), 64'h0);
        bus.data_yumi_i = 1'b1;
        chk("bp_head_v", 64'(bus.data_v_o), 64'h1);
        chk("bp_head", 64'(bus.data_o), 64'h8000_0000);
        adv();
        bus.data_yumi_i = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b0, a0 + 39'(4 * k), p0);
            to_neg();
            adv();
            if (s_hs) n_hs++;
            if (s_req_yumi) k++;
        end
        chk("bp_one_more", 64'(n_hs), 64'h1);
        set_req(1'b0, 1'b0, z0, pz);
        bus.data_yumi_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            addr = a0 + 39'(4 * i);
            to_neg();
            chk($sformatf("bp_drain%0d", i), 64'(bus.data_o), 64'(addr[31:0]));
            adv();
        end
        to_neg();
        chk("bp_drained", 64'(bus.data_v_o), 64'h0);
        adv();

        // ---- miss during replay: A misses twice, B behind it ----
        do_reset();
        miss_addr = a0;
        miss_left = 2;
        bus.data_yumi_i = 1'b1;
        k = 0; n_hs = 0; n_out = 0;
        for (int i = 0; i < 30; i++) begin
            set_req(k < 2, 1'b0, a0 + 39'(4 * k), p0);
            to_neg();
            adv();
            if (s_hs && n_hs < 8) begin hs_log[n_hs] = s_addr; n_hs++; end
            if (s_dv && n_out < 8) begin out_log[n_out] = s_data; n_out++; end
            if (s_req_yumi) k++;
        end
        exp_hs[0] = a0; exp_hs[1] = a1; exp_hs[2] = a0;
        exp_hs[3] = a1; exp_hs[4] = a0; exp_hs[5] = a1;
        chk("rr_issue_count", 64'(n_hs), 64'h6);
        for (int i = 0; i < 6; i++) begin
            if (i < n_hs) chk($sformatf("rr_issue%0d", i), 64'(hs_log[i]), 64'(exp_hs[i]));
        end
        chk("rr_out_count", 64'(n_out), 64'h2);
        if (n_out > 0) chk("rr_out0", 64'(out_log[0]), 64'h8000_0000);
        if (n_out > 1) chk("rr_out1", 64'(out_log[1]), 64'h8000_0004);
        to_neg();
        chk("rr_miss_cnt", 64'(bus.miss_cnt_o), 64'h2);
        adv();

        // ---- reset with two in flight and two buffered ----
        bus.data_yumi_i = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 39'h00_8000_0200 + 39'(4 * k), p0);
            to_neg();
            adv();
            if (s_req_yumi) k++;
        end
        set_req(1'b0, 1'b0, z0, pz);
        reset = 1'b1;
        to_neg();
        chk("mr_pre_issued", 64'(k), 64'h4);
        chk("mr_pre_data", 64'(bus.data_o), 64'h8000_0200);
        adv();
        reset = 1'b0;
        to_neg();
        chk_all_zero("mr");
        adv();
        set_req(1'b1, 1'b0, 39'h00_8000_0300, p3);
        to_neg();
        chk("mr_issue", 64'(bus.req_yumi_o), 64'h1);
        adv();
        set_req(1'b0, 1'b0, z0, pz);
        bus.data_yumi_i = 1'b1;
        to_neg();
        chk("mr_ptag", 64'(bus.ptag_o), 64'(p3));
        adv();
        to_neg();
        adv();
        to_neg();
        chk("mr_data_v", 64'(bus.data_v_o), 64'h1);
        chk("mr_data", 64'(bus.data_o), 64'h8000_0300);
        adv();
        to_neg();
        chk("mr_fetch_cnt", 64'(bus.fetch_cnt_o), 64'h1);
        chk("mr_miss_cnt", 64'(bus.miss_cnt_o), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
